axil_cmd_ctrl: RTL and testbench

AXI4-Lite write-channel controller that accepts host register writes from the PCIe SGDMA user path, decodes command words and sequences the board LED and the scan stop request. It sits between the AXI-Lite master port of the SGDMA IP and the user logic. It provides proper AW/W/B handshaking, a blink pattern generator and a stop request/acknowledge handshake.

---
 rtl/axil_cmd_pkg.sv | 39 +++
 rtl/led_pattern_gen.sv | 70 +++++++
 rtl/axil_cmd_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axil_cmd_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_cmd_pkg.sv
// ---------------------------------------------------------------------------
// axil_cmd_pkg
// Shared definitions for the AXI4-Lite command controller:
//   - command magic words written to the CMD register
//   - register byte offsets
//   - AXI write response codes
//   - write-channel FSM state and LED mode enumerations
// ---------------------------------------------------------------------------
package axil_cmd_pkg;

  // Command words accepted at the CMD register
  localparam logic [31:0] CMD_LED_ON    = 32'h1234abcd;
  localparam logic [31:0] CMD_LED_OFF   = 32'h0011aabb;
  localparam logic [31:0] CMD_LED_BLINK = 32'h5a5a0001;
  localparam logic [31:0] CMD_STOP      = 32'h11223344;

  // Register offsets (byte addresses)
  localparam logic [11:0] REG_CMD          = 12'h000;
  localparam logic [11:0] REG_BLINK_PERIOD = 12'h004;

  // Write response codes
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // Write-channel FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } axi_state_t;

  // LED behaviour
  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2
  } led_mode_t;

endpackage

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Drives the board LED from the current LED mode. In BLINK mode a counter
// runs 0..period-1 and the LED toggles on the cycle the counter wraps.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_load         one-cycle strobe: a new mode command is being applied
//   i_load_mode    mode carried by that command
//   i_mode         currently active mode (registered in the parent)
//   i_period       programmed blink period (always >= 1)
//   o_led          registered LED drive
// ---------------------------------------------------------------------------
module led_pattern_gen
  import axil_cmd_pkg::*;
#(
  parameter int unsigned BLINK_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  led_mode_t          i_load_mode,
  input  led_mode_t          i_mode,
  input  logic [BLINK_W-1:0] i_period,
  output logic               o_led
);

  logic [BLINK_W-1:0] r_cnt;
  // Period in use by the running pattern; the programmed value is only
  // picked up on BLINK entry and at each wrap, so a rewrite mid-period
  // never truncates or stretches the current half-cycle.
  logic [BLINK_W-1:0] r_period_cur;
  logic               r_led;
  logic               w_wrap;

  assign w_wrap = (r_cnt == (r_period_cur - BLINK_W'(1)));
  assign o_led  = r_led;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_period_cur <= BLINK_W'(1);
      r_led        <= 1'b0;
    end else if (i_load) begin
      case (i_load_mode)
        LED_ON: begin
          r_led <= 1'b1;
        end
        LED_BLINK: begin
          // Every BLINK command restarts the pattern from a lit LED.
          r_led        <= 1'b1;
          r_cnt        <= '0;
          r_period_cur <= i_period;
        end
        default: begin
          r_led <= 1'b0;
        end
      endcase
    end else if (i_mode == LED_BLINK) begin
      if (w_wrap) begin
        r_cnt        <= '0;
        r_led        <= ~r_led;
        r_period_cur <= i_period;
      end else begin
        r_cnt <= r_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: rtl/axil_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// axil_cmd_ctrl
// AXI4-Lite write-only slave that decodes host command words, programs the
// LED blink period and runs the stop request / acknowledge handshake.
//
// Ports:
//   usr_clk, usr_rst                  clock, asynchronous active-high reset
//   s_axil_aw{valid,ready,addr}       write address channel
//   s_axil_w{valid,ready,data,strb}   write data channel
//   s_axil_b{valid,ready,resp}        write response channel
//   stop_ack                          user logic acknowledges stop_req
//   led0                              LED drive
//   stop_req                          stop requested, awaiting ack
//   stop                              sticky stopped flag
//   busy                              a write transaction is in flight
// ---------------------------------------------------------------------------
module axil_cmd_ctrl
  import axil_cmd_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 12,
  parameter int unsigned        BLINK_W   = 24,
  parameter logic [BLINK_W-1:0] BLINK_DEF = 24'd8
) (
  input  logic              usr_clk,
  input  logic              usr_rst,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  output logic [1:0]        s_axil_bresp,
  input  logic              stop_ack,
  output logic              led0,
  output logic              stop_req,
  output logic              stop,
  output logic              busy
);

  axi_state_t         r_state, w_state_next;
  logic               r_aw_cap, r_w_cap;
  logic               w_aw_cap_next, w_w_cap_next;
  logic [ADDR_W-1:0]  r_awaddr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_awready, r_wready, r_bvalid, r_busy;
  logic [1:0]         r_bresp;
  led_mode_t          r_led_mode;
  logic [BLINK_W-1:0] r_period;
  logic               r_stop_req, r_stop;

  logic               w_aw_hs, w_w_hs, w_b_hs, w_exec;
  logic [1:0]         w_bresp_next;
  logic               w_mode_load;
  led_mode_t          w_mode_new;
  logic               w_stop_set;
  logic               w_period_wr;
  logic [31:0]        w_period_ext;
  logic [31:0]        w_period_merge;
  logic [BLINK_W-1:0] w_period_new;
  logic               w_unused_period_hi;
  logic               w_led;

  assign w_aw_hs = s_axil_awvalid & r_awready;
  assign w_w_hs  = s_axil_wvalid & r_wready;
  assign w_b_hs  = r_bvalid & s_axil_bready;
  assign w_exec  = (r_state == ST_EXEC);

  // -------------------------------------------------------------------------
  // Write-channel FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_aw_cap_next = r_aw_cap;
    w_w_cap_next  = r_w_cap;
    if (w_aw_hs) begin
      w_aw_cap_next = 1'b1;
    end
    if (w_w_hs) begin
      w_w_cap_next = 1'b1;
    end
    case (r_state)
      ST_IDLE: begin
        // Both halves must already be registered, so EXEC always sees
        // stable address and data regardless of arrival order.
        if (r_aw_cap && r_w_cap) begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (w_b_hs) begin
          w_state_next  = ST_IDLE;
          w_aw_cap_next = 1'b0;
          w_w_cap_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next-state view so they are
  // correct on the very edge the state changes.
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_bresp   <= BRESP_OKAY;
    end else begin
      r_aw_cap  <= w_aw_cap_next;
      r_w_cap   <= w_w_cap_next;
      r_awready <= (w_state_next == ST_IDLE) && !w_aw_cap_next;
      r_wready  <= (w_state_next == ST_IDLE) && !w_w_cap_next;
      r_bvalid  <= (w_state_next == ST_RESP);
      r_busy    <= (w_state_next != ST_IDLE);
      if (w_aw_hs) begin
        r_awaddr <= s_axil_awaddr;
      end
      if (w_w_hs) begin
        r_wdata <= s_axil_wdata;
        r_wstrb <= s_axil_wstrb;
      end
      // bresp is only written in EXEC, so it holds through RESP back-pressure.
      if (w_exec) begin
        r_bresp <= w_bresp_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register decode (consumed only during EXEC)
  // -------------------------------------------------------------------------
  always_comb begin
    w_bresp_next = BRESP_OKAY;
    w_mode_load  = 1'b0;
    w_mode_new   = r_led_mode;
    w_stop_set   = 1'b0;
    w_period_wr  = 1'b0;
    if (r_awaddr == ADDR_W'(REG_CMD)) begin
      // Command words are only meaningful as a whole 32-bit write.
      if (r_wstrb != 4'hF) begin
        w_bresp_next = BRESP_SLVERR;
      end else begin
        case (r_wdata)
          CMD_LED_ON: begin
            w_mode_load = 1'b1;
            w_mode_new  = LED_ON;
          end
          CMD_LED_OFF: begin
            w_mode_load = 1'b1;
            w_mode_new  = LED_OFF;
          end
          CMD_LED_BLINK: begin
            w_mode_load = 1'b1;
            w_mode_new  = LED_BLINK;
          end
          CMD_STOP: begin
            w_stop_set = !r_stop_req && !r_stop;
          end
          default: begin
            w_mode_load = 1'b0;
          end
        endcase
      end
    end else if (r_awaddr == ADDR_W'(REG_BLINK_PERIOD)) begin
      w_period_wr = 1'b1;
    end else begin
      w_bresp_next = BRESP_SLVERR;
    end
  end

  // Byte-strobe merge of the period register against its current value
  always_comb begin
    w_period_ext                = '0;
    w_period_ext[BLINK_W-1:0]   = r_period;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_strb
    assign w_period_merge[8*gi +: 8] = r_wstrb[gi] ? r_wdata[8*gi +: 8]
                                                   : w_period_ext[8*gi +: 8];
  end

  // A zero period would never wrap; clamp it to the fastest legal rate.
  assign w_period_new = (w_period_merge[BLINK_W-1:0] == '0) ? BLINK_W'(1)
                                                            : w_period_merge[BLINK_W-1:0];
  // Bits above BLINK_W are accepted on the bus but not stored.
  assign w_unused_period_hi = ^w_period_merge;

  // -------------------------------------------------------------------------
  // Control registers and stop handshake
  // -------------------------------------------------------------------------
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_led_mode <= LED_OFF;
      r_period   <= BLINK_DEF;
      r_stop_req <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      if (w_exec && w_mode_load) begin
        r_led_mode <= w_mode_new;
      end
      if (w_exec && w_period_wr) begin
        r_period <= w_period_new;
      end
      // The set path requires r_stop_req == 0 and the ack path requires it
      // set, so the two never act in the same cycle; an ack arriving with
      // the stop command's EXEC is therefore dropped.
      if (w_exec && w_stop_set) begin
        r_stop_req <= 1'b1;
      end else if (stop_ack && r_stop_req) begin
        r_stop_req <= 1'b0;
        r_stop     <= 1'b1;
      end
    end
  end

  led_pattern_gen #(
    .BLINK_W (BLINK_W)
  ) u_led_pattern_gen (
    .i_clk       (usr_clk),
    .i_rst       (usr_rst),
    .i_load      (w_exec && w_mode_load),
    .i_load_mode (w_mode_new),
    .i_mode      (r_led_mode),
    .i_period    (r_period),
    .o_led       (w_led)
  );

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign led0           = w_led;
  assign stop_req       = r_stop_req;
  assign stop           = r_stop;
  assign busy           = r_busy;

endmodule

// File: tb/tb_axil_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axil_cmd_ctrl
// Directed bench: a table of single write transactions with expected
// response and LED/stop state, followed by hand-written multi-cycle
// sequences (W before AW, blink timing, stop handshake, response
// back-pressure, zero/partial period writes, reset during EXEC).
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_axil_cmd_ctrl;

  localparam logic [31:0] C_ON    = 32'h1234abcd;
  localparam logic [31:0] C_OFF   = 32'h0011aabb;
  localparam logic [31:0] C_BLINK = 32'h5a5a0001;
  localparam logic [31:0] C_STOP  = 32'h11223344;

  logic        usr_clk        = 1'b0;
  logic        usr_rst        = 1'b1;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [11:0] s_axil_awaddr  = 12'h000;
  logic        s_axil_wvalid  = 1'b0;
  logic        s_axil_wready;
  logic [31:0] s_axil_wdata   = 32'h0;
  logic [3:0]  s_axil_wstrb   = 4'h0;
  logic        s_axil_bvalid;
  logic        s_axil_bready  = 1'b0;
  logic [1:0]  s_axil_bresp;
  logic        stop_ack       = 1'b0;
  logic        led0;
  logic        stop_req;
  logic        stop;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 usr_clk = ~usr_clk;

  axil_cmd_ctrl #(
    .ADDR_W    (12),
    .BLINK_W   (24),
    .BLINK_DEF (24'd8)
  ) dut (
    .usr_clk        (usr_clk),
    .usr_rst        (usr_rst),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_bresp   (s_axil_bresp),
    .stop_ack       (stop_ack),
    .led0           (led0),
    .stop_req       (stop_req),
    .stop           (stop),
    .busy           (busy)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic        led;
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one write. aw_delay = 0 presents AW and W together; otherwise W
  // goes first and AW follows aw_delay cycles after the W handshake.
  // Returns on the falling edge after bvalid should have risen.
  task automatic write_start(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay,
                             input logic ack_exec, output logic [1:0] resp);
    int n;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    s_axil_wvalid = 1'b1;
    s_axil_awaddr = addr;
    if (aw_delay == 0) s_axil_awvalid = 1'b1;
    n = 0;
    while (!(s_axil_wready && (aw_delay != 0 || s_axil_awready)) && n < 20) begin
      @(negedge usr_clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 20), 32'd1);
    @(negedge usr_clk);
    s_axil_wvalid = 1'b0;
    if (aw_delay == 0) begin
      s_axil_awvalid = 1'b0;
    end else begin
      chk("w_only_wready", 32'(s_axil_wready), 32'd0);
      chk("w_only_awready", 32'(s_axil_awready), 32'd1);
      repeat (aw_delay - 1) @(negedge usr_clk);
      s_axil_awvalid = 1'b1;
      @(negedge usr_clk);
      s_axil_awvalid = 1'b0;
    end
    chk("bvalid_k0", 32'(s_axil_bvalid), 32'd0);
    @(negedge usr_clk);
    if (ack_exec) stop_ack = 1'b1;
    chk("bvalid_k1", 32'(s_axil_bvalid), 32'd0);
    chk("busy_k1", 32'(busy), 32'd1);
    @(negedge usr_clk);
    stop_ack = 1'b0;
    chk("bvalid_k2", 32'(s_axil_bvalid), 32'd1);
    resp = s_axil_bresp;
    $display("txn addr=%03h data=%08h strb=%h bresp=%0d led0=%0d stop_req=%0d stop=%0d",
             addr, data, strb, resp, led0, stop_req, stop);
  endtask

  // Finish the response, optionally holding bready low for `hold` cycles
  // while offering a new AW/W that must not be taken.
  task automatic b_complete(input int hold, input logic [1:0] exp_resp);
    if (hold > 0) begin
      s_axil_awaddr  = 12'h000;
      s_axil_wdata   = C_OFF;
      s_axil_wstrb   = 4'hF;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge usr_clk);
      chk("hold_bvalid", 32'(s_axil_bvalid), 32'd1);
      chk("hold_bresp", 32'(s_axil_bresp), 32'(exp_resp));
      chk("hold_awready", 32'(s_axil_awready), 32'd0);
      chk("hold_wready", 32'(s_axil_wready), 32'd0);
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b1;
    @(negedge usr_clk);
    s_axil_bready = 1'b0;
    chk("b_done_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("b_done_awready", 32'(s_axil_awready), 32'd1);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    write_start(addr, data, strb, 0, 1'b0, resp);
    chk("wr_bresp", 32'(resp), 32'(exp_resp));
    b_complete(0, exp_resp);
  endtask

  // Issue BLINK and compare led0 on n consecutive falling edges starting at
  // the edge bvalid rises; bit i of pat is the expected value at sample i.
  task automatic blink_check(input string name, input logic [15:0] pat, input int n);
    logic [1:0] resp;
    write_start(12'h000, C_BLINK, 4'hF, 0, 1'b0, resp);
    chk({name, "_bresp"}, 32'(resp), 32'd0);
    chk($sformatf("%s_s0", name), 32'(led0), 32'(pat[0]));
    b_complete(0, 2'b00);
    chk($sformatf("%s_s1", name), 32'(led0), 32'(pat[1]));
    for (int i = 2; i < n; i++) begin
      @(negedge usr_clk);
      chk($sformatf("%s_s%0d", name, i), 32'(led0), 32'(pat[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;

    vecs[0] = '{12'h000, C_ON,          4'hF, 2'b00, 1'b1};
    vecs[1] = '{12'h000, C_OFF,         4'hF, 2'b00, 1'b0};
    vecs[2] = '{12'h000, C_ON,          4'h3, 2'b10, 1'b0};
    vecs[3] = '{12'h008, C_ON,          4'hF, 2'b10, 1'b0};
    vecs[4] = '{12'h000, C_ON,          4'hF, 2'b00, 1'b1};
    vecs[5] = '{12'h000, 32'hdeadbeef,  4'hF, 2'b00, 1'b1};
    vecs[6] = '{12'h00c, C_OFF,         4'hF, 2'b10, 1'b1};
    vecs[7] = '{12'h000, C_OFF,         4'h7, 2'b10, 1'b1};
    vecs[8] = '{12'h000, C_OFF,         4'hF, 2'b00, 1'b0};

    // Reset values
    repeat (2) @(negedge usr_clk);
    chk("rst_awready", 32'(s_axil_awready), 32'd0);
    chk("rst_wready", 32'(s_axil_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("rst_bresp", 32'(s_axil_bresp), 32'd0);
    chk("rst_led0", 32'(led0), 32'd0);
    chk("rst_stop_req", 32'(stop_req), 32'd0);
    chk("rst_stop", 32'(stop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    usr_rst = 1'b0;
    @(negedge usr_clk);
    chk("post_rst_awready", 32'(s_axil_awready), 32'd1);
    chk("post_rst_wready", 32'(s_axil_wready), 32'd1);

    // Table of single transactions (AW and W together)
    for (int i = 0; i < 9; i++) begin
      write_start(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 1'b0, resp);
      chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].bresp));
      chk($sformatf("vec%0d_led0", i), 32'(led0), 32'(vecs[i].led));
      chk($sformatf("vec%0d_stop_req", i), 32'(stop_req), 32'd0);
      chk($sformatf("vec%0d_stop", i), 32'(stop), 32'd0);
      b_complete(0, vecs[i].bresp);
    end

    // W first, AW three cycles later: period = 3, then blink
    write_start(12'h004, 32'd3, 4'hF, 3, 1'b0, resp);
    chk("wfirst_bresp", 32'(resp), 32'd0);
    b_complete(0, 2'b00);
    blink_check("blink3", 16'h0047, 7);

    // Stop handshake
    wr(12'h000, C_OFF, 4'hF, 2'b00);
    chk("off_led0", 32'(led0), 32'd0);
    stop_ack = 1'b1;
    @(negedge usr_clk);
    stop_ack = 1'b0;
    chk("stray_ack_stop_req", 32'(stop_req), 32'd0);
    chk("stray_ack_stop", 32'(stop), 32'd0);
    write_start(12'h000, C_STOP, 4'hF, 0, 1'b0, resp);
    chk("stop_bresp", 32'(resp), 32'd0);
    chk("stop_req_set", 32'(stop_req), 32'd1);
    chk("stop_not_yet", 32'(stop), 32'd0);
    b_complete(0, 2'b00);
    for (int i = 2; i <= 4; i++) begin
      @(negedge usr_clk);
      chk($sformatf("stop_req_wait%0d", i), 32'(stop_req), 32'd1);
    end
    stop_ack = 1'b1;
    @(negedge usr_clk);
    stop_ack = 1'b0;
    chk("ack_stop_req", 32'(stop_req), 32'd0);
    chk("ack_stop", 32'(stop), 32'd1);
    repeat (3) @(negedge usr_clk);
    chk("stop_sticky", 32'(stop), 32'd1);
    write_start(12'h000, C_STOP, 4'hF, 0, 1'b0, resp);
    chk("stop2_bresp", 32'(resp), 32'd0);
    chk("stop2_stop_req", 32'(stop_req), 32'd0);
    chk("stop2_stop", 32'(stop), 32'd1);
    b_complete(0, 2'b00);
    wr(12'h000, C_ON, 4'hF, 2'b00);
    chk("on_after_stop_led0", 32'(led0), 32'd1);

    // Error responses with back-pressure on B
    write_start(12'h008, C_OFF, 4'hF, 0, 1'b0, resp);
    chk("bad_addr_bresp", 32'(resp), 32'd2);
    chk("bad_addr_led0", 32'(led0), 32'd1);
    b_complete(4, 2'b10);
    chk("after_hold_led0", 32'(led0), 32'd1);
    write_start(12'h000, C_OFF, 4'h3, 0, 1'b0, resp);
    chk("part_strb_bresp", 32'(resp), 32'd2);
    chk("part_strb_led0", 32'(led0), 32'd1);
    b_complete(0, 2'b10);

    // Zero period is stored as 1: toggle every cycle
    wr(12'h004, 32'd0, 4'hF, 2'b00);
    wr(12'h000, C_OFF, 4'hF, 2'b00);
    blink_check("blink1", 16'h0015, 6);

    // Byte-strobed period write: only byte 0 lands, period becomes 4
    wr(12'h000, C_OFF, 4'hF, 2'b00);
    wr(12'h004, 32'h0000_0204, 4'h1, 2'b00);
    blink_check("blink4", 16'h010F, 9);

    // Reset during EXEC aborts the transaction (a period write of 2)
    wr(12'h000, C_ON, 4'hF, 2'b00);
    s_axil_awaddr  = 12'h004;
    s_axil_wdata   = 32'd2;
    s_axil_wstrb   = 4'hF;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    @(negedge usr_clk);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    @(negedge usr_clk);
    chk("exec_busy", 32'(busy), 32'd1);
    usr_rst = 1'b1;
    #1;
    chk("mid_rst_led0", 32'(led0), 32'd0);
    chk("mid_rst_stop", 32'(stop), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("mid_rst_awready", 32'(s_axil_awready), 32'd0);
    @(negedge usr_clk);
    usr_rst = 1'b0;
    @(negedge usr_clk);
    chk("rerst_awready", 32'(s_axil_awready), 32'd1);
    chk("rerst_bvalid", 32'(s_axil_bvalid), 32'd0);
    chk("rerst_stop", 32'(stop), 32'd0);
    blink_check("blink_def", 16'h00FF, 10);

    // stop_ack coinciding with the stop command's EXEC is ignored
    wr(12'h000, C_OFF, 4'hF, 2'b00);
    write_start(12'h000, C_STOP, 4'hF, 0, 1'b1, resp);
    chk("ackexec_bresp", 32'(resp), 32'd0);
    chk("ackexec_stop_req", 32'(stop_req), 32'd1);
    chk("ackexec_stop", 32'(stop), 32'd0);
    b_complete(0, 2'b00);
    stop_ack = 1'b1;
    @(negedge usr_clk);
    stop_ack = 1'b0;
    chk("ackexec_late_stop_req", 32'(stop_req), 32'd0);
    chk("ackexec_late_stop", 32'(stop), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
